hdmi_mm_write_arbiter: RTL and testbench
========================================

// Module: hdmi_mm_write_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single HDMI frame-buffer Avalon-MM write slave
//  (slave_write/address/writedata/burstcount/waitrequest) between NREQ write masters,
//  e.g. the test-pattern writer and a DMA/CPU path. Grants whole bursts, never splits one.
//  Sits between the requesters and the hdmi core's avalon slave, in the clk_mm domain.
// PARAMETERS
//  NREQ  2   number of requesters (2..8)
//  AW    10  avalon word address width
//  DW    32  write data width
//  BW    4   burstcount width; legal bursts 1..2**BW-1, value 0 treated as 1
// PORTS
//  clk            in   1         clk_mm, all logic on rising edge
//  reset_n        in   1         synchronous, active-low reset
//  en             in   1         1 = new grants allowed; 0 = finish current burst, then hold
//  req_write      in   NREQ      per-requester write strobe
//  req_address    in   NREQ*AW   flattened, requester k at [k*AW +: AW]
//  req_writedata  in   NREQ*DW   flattened, requester k at [k*DW +: DW]
//  req_burstcount in   NREQ*BW   flattened, sampled on first beat only
//  req_waitrequest out NREQ      per-requester stall, 1 = not accepted
//  slave_write    out  1         to hdmi slave
//  slave_address  out  AW        to hdmi slave
//  slave_writedata out DW        to hdmi slave
//  slave_burstcount out BW       to hdmi slave
//  slave_waitrequest in 1        from hdmi slave
//  grant          out  NREQ      one-hot current owner, 0 when idle
//  busy           out  1         1 while in BURST
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, ptr=0, beats_left=0, busy=0; slave_write=0,
//   slave_address/writedata/burstcount=0, req_waitrequest=all 1. Reset mid-burst
//   aborts the burst at once (no further beats driven).
//  FSM IDLE:
//   - Slave outputs are 0 and all req_waitrequest are 1.
//   - If en && |req_write: pick the first asserted requester at or after ptr
//     (cyclic search); register grant; beats_left = burstcount (0 -> 1); go to BURST.
//   - Otherwise stay in IDLE.
//  FSM BURST:
//   - Slave outputs mux straight from the granted requester (combinational).
//   - slave_burstcount = latched burst value.
//   - Granted requester's waitrequest = slave_waitrequest; all others = 1.
//   - Beat accepted when granted req_write && !slave_waitrequest: beats_left--.
//   - Accepting the beat with beats_left==1: go to IDLE, grant=0,
//     ptr = (owner+1) mod NREQ.
//   - Granted req_write low mid-burst: stay in BURST, no beat counted (master may pause).
//  Latency: req_write at cycle t in IDLE -> slave_write high at t+1 (zero-wait slave
//   accepts at t+1). Exactly one idle cycle between consecutive bursts.
//  en dropped during BURST: the burst completes; no new grant while en=0.
//  Simultaneous requests: only ptr decides, e.g. ptr=1, NREQ=2, both request -> req 1 wins.
//  Grant changes only on the IDLE->BURST edge, never while any beat is pending.
//  Counting: beats_left is BW bits; it can never underflow (exit at 1).
// TESTING
//  1 Single req0, burst=1, slave never waits -> slave_write 1 cycle after req, grant=01,
//    then IDLE; ptr=1.
//  2 req0 and req1 held continuously, burst=4, no waits -> grants alternate 0,1,0,...;
//    each burst 4 beats + 1 idle cycle; never 2 grants at once.
//  3 req1 burst=3, slave_waitrequest high for 5 cycles on beat 2 -> data/address held,
//    exactly 3 beats counted, req0 waitrequest stays 1 throughout.
//  4 burstcount=0 from req0 -> treated as 1 beat, returns to IDLE after one accept.
//  5 en low with req0 pending -> no grant; en high -> grant next cycle. en low mid
//    burst=4 -> all 4 beats complete, then idle.
//  6 reset_n low at beat 2 of burst=8 -> next cycle slave_write=0, grant=0, ptr=0,
//    all waitrequest=1.

Source files
------------

// File: rtl/hdmi_mm_write_arbiter_if.sv
// Requester-side and hdmi-slave-side Avalon-MM write signals seen by the arbiter.
interface hdmi_mm_write_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 32,
    parameter int unsigned BW   = 4
);
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_address;
    logic [NREQ*DW-1:0] req_writedata;
    logic [NREQ*BW-1:0] req_burstcount;
    logic [NREQ-1:0]    req_waitrequest;

    logic               slave_write;
    logic [AW-1:0]      slave_address;
    logic [DW-1:0]      slave_writedata;
    logic [BW-1:0]      slave_burstcount;
    logic               slave_waitrequest;

    // Environment view: the write masters plus the hdmi avalon slave.
    modport master (
        output req_write, req_address, req_writedata, req_burstcount,
        input  req_waitrequest,
        input  slave_write, slave_address, slave_writedata, slave_burstcount,
        output slave_waitrequest
    );

    // Arbiter view: slave to the requesters, master to the hdmi slave.
    modport slave (
        input  req_write, req_address, req_writedata, req_burstcount,
        output req_waitrequest,
        output slave_write, slave_address, slave_writedata, slave_burstcount,
        input  slave_waitrequest
    );
endinterface

// File: rtl/hdmi_mm_write_arbiter.sv
// Round-robin arbiter sharing the hdmi frame-buffer Avalon-MM write slave between
// NREQ write masters. Whole bursts are granted; a burst is never split.
module hdmi_mm_write_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 32,
    parameter int unsigned BW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    hdmi_mm_write_arbiter_if.slave bus,
    output logic [NREQ-1:0]  grant,
    output logic             busy
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [BW-1:0]   beats_left_q, beats_left_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [NREQ-1:0] grant_q, grant_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [BW-1:0]   win_bc;
    logic            own_write;
    logic            beat_acc;

    // Cyclic first-asserted search starting at the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && bus.req_write[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
        end
    end

    // Burst length of the winner; a zero burstcount means a single beat.
    always_comb begin
        win_bc = bus.req_burstcount[win_idx*BW +: BW];
        if (win_bc == '0) begin
            win_bc = BW'(1);
        end
    end

    assign own_write = bus.req_write[owner_q];
    assign beat_acc  = (state_q == BURST) && own_write && !bus.slave_waitrequest;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            beats_left_q <= '0;
            burst_q      <= '0;
            grant_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
            burst_q      <= burst_d;
            grant_q      <= grant_d;
        end
    end

    // Next-state logic and the slave/requester mux.
    always_comb begin
        state_d              = state_q;
        ptr_d                = ptr_q;
        owner_d              = owner_q;
        beats_left_d         = beats_left_q;
        burst_d              = burst_q;
        grant_d              = grant_q;
        bus.slave_write      = 1'b0;
        bus.slave_address    = '0;
        bus.slave_writedata  = '0;
        bus.slave_burstcount = '0;
        bus.req_waitrequest  = '1;

        case (state_q)
            IDLE: begin
                if (en && win_found) begin
                    state_d      = BURST;
                    owner_d      = win_idx;
                    grant_d      = NREQ'(1) << win_idx;
                    beats_left_d = win_bc;
                    burst_d      = win_bc;
                end
            end
            BURST: begin
                bus.slave_write      = own_write;
                bus.slave_address    = bus.req_address[owner_q*AW +: AW];
                bus.slave_writedata  = bus.req_writedata[owner_q*DW +: DW];
                bus.slave_burstcount = burst_q;
                bus.req_waitrequest[owner_q] = bus.slave_waitrequest;
                if (beat_acc) begin
                    if (beats_left_q == BW'(1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                    end else begin
                        beats_left_d = beats_left_q - BW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q == BURST);

endmodule

// File: tb/tb_hdmi_mm_write_arbiter.sv
// Directed and randomized bench for hdmi_mm_write_arbiter against a transaction-level model.
module tb_hdmi_mm_write_arbiter;
    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            en;
    logic [NREQ-1:0] grant;
    logic            busy;

    always #5 clk = ~clk;

    hdmi_mm_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .BW(BW)) bus ();

    hdmi_mm_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BW(BW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .bus     (bus),
        .grant   (grant),
        .busy    (busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: who owns the slave, beats still owed, latched length, next-first pointer.
    int m_busy  = 0;
    int m_owner = 0;
    int m_left  = 0;
    int m_bc    = 0;
    int m_ptr   = 0;
    int beats_obs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs for the current cycle, then advance the model across the edge.
    task automatic step();
        logic [NREQ-1:0] ew;
        logic [NREQ-1:0] eg;
        int bc;
        #1;
        eg = '0;
        ew = '1;
        if (m_busy != 0) begin
            eg[m_owner] = 1'b1;
            ew[m_owner] = bus.slave_waitrequest;
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("onehot", 64'($onehot0(grant)), 64'(1));
        chk("busy", 64'(busy), 64'(m_busy != 0));
        chk("waitrequest", 64'(bus.req_waitrequest), 64'(ew));
        if (m_busy != 0) begin
            chk("slave_write", 64'(bus.slave_write), 64'(bus.req_write[m_owner]));
            chk("slave_address", 64'(bus.slave_address), 64'(bus.req_address[m_owner*AW +: AW]));
            chk("slave_writedata", 64'(bus.slave_writedata), 64'(bus.req_writedata[m_owner*DW +: DW]));
            chk("slave_burstcount", 64'(bus.slave_burstcount), 64'(m_bc));
        end else begin
            chk("idle_slave", {bus.slave_write, bus.slave_burstcount, bus.slave_address,
                               bus.slave_writedata}, 64'(0));
        end
        if (bus.slave_write && !bus.slave_waitrequest) beats_obs++;
        @(posedge clk);
        if (!reset_n) begin
            m_busy = 0;
            m_ptr  = 0;
            m_left = 0;
        end else if (m_busy == 0) begin
            if (en && (|bus.req_write)) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_write[(m_ptr + i) % NREQ]) begin
                        m_owner = (m_ptr + i) % NREQ;
                        break;
                    end
                end
                bc     = int'(bus.req_burstcount[m_owner*BW +: BW]);
                m_bc   = (bc == 0) ? 1 : bc;
                m_left = m_bc;
                m_busy = 1;
            end
        end else if (bus.req_write[m_owner] && !bus.slave_waitrequest) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % NREQ;
            end
        end
        @(negedge clk);
    endtask

    // Let the current owner finish its burst with a zero-wait slave.
    task automatic drain();
        bus.slave_waitrequest = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.req_write = grant;
            step();
            if (!busy) break;
        end
        bus.req_write = '0;
        chk("drain_idle", 64'(busy), 64'(0));
    endtask

    task automatic set_req(input int k, input int addr, input int data, input int bc);
        bus.req_address[k*AW +: AW]    = AW'(addr);
        bus.req_writedata[k*DW +: DW]  = DW'(data);
        bus.req_burstcount[k*BW +: BW] = BW'(bc);
    endtask

    initial begin
        int wc;
        reset_n               = 1'b0;
        en                    = 1'b0;
        bus.req_write         = '0;
        bus.req_address       = '0;
        bus.req_writedata     = '0;
        bus.req_burstcount    = '0;
        bus.slave_waitrequest = 1'b0;
        @(negedge clk);
        step();
        step();
        reset_n = 1'b1;
        en      = 1'b1;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_waitreq", 64'(bus.req_waitrequest), 64'({NREQ{1'b1}}));

        // 1: single req0 burst of one; grant and slave_write one cycle later.
        set_req(0, 10'h005, 32'hA5A5_0001, 1);
        bus.req_write = 2'b01;
        step();
        chk("t1_grant", 64'(grant), 64'(2'b01));
        chk("t1_latency", 64'(bus.slave_write), 64'(1));
        step();
        bus.req_write = '0;
        chk("t1_idle", 64'(busy), 64'(0));
        // pointer now 1: both requesting, requester 1 wins
        set_req(1, 10'h111, 32'hB0B0_0001, 1);
        bus.req_write = 2'b11;
        step();
        chk("t1_ptr", 64'(grant), 64'(2'b10));
        drain();

        // 2: both held, bursts of 4, alternating grants.
        set_req(0, 10'h020, 32'h0000_0020, 4);
        set_req(1, 10'h040, 32'h0000_0040, 4);
        bus.req_write = 2'b11;
        repeat (30) step();
        drain();

        // 3: req1 burst of 3 with five wait cycles on beat 2.
        set_req(1, 10'h300, 32'h3333_0000, 3);
        beats_obs = 0;
        wc = 0;
        for (int c = 0; c < 30; c++) begin
            if (busy && beats_obs == 1 && wc < 5) begin
                bus.slave_waitrequest = 1'b1;
                wc++;
            end else begin
                bus.slave_waitrequest = 1'b0;
            end
            bus.req_write = (beats_obs < 3) ? 2'b10 : 2'b00;
            step();
            set_req(1, 10'h300 + beats_obs, 32'h3333_0000 + beats_obs, 3);
            if (beats_obs == 3 && !busy) break;
        end
        bus.req_write         = '0;
        bus.slave_waitrequest = 1'b0;
        chk("t3_beats", 64'(beats_obs), 64'(3));
        chk("t3_waits", 64'(wc), 64'(5));

        // 4: burstcount 0 means one beat.
        set_req(0, 10'h044, 32'h4444_4444, 0);
        bus.req_write = 2'b01;
        step();
        chk("t4_bc", 64'(bus.slave_burstcount), 64'(1));
        step();
        bus.req_write = '0;
        chk("t4_idle", 64'(busy), 64'(0));

        // 5: en gates new grants; en low mid-burst lets the burst finish.
        en = 1'b0;
        set_req(0, 10'h055, 32'h5555_0000, 4);
        bus.req_write = 2'b01;
        repeat (3) step();
        chk("t5_hold", 64'(grant), 64'(0));
        en = 1'b1;
        step();
        chk("t5_grant", 64'(grant), 64'(2'b01));
        en = 1'b0;
        repeat (4) step();
        chk("t5_done", 64'(busy), 64'(0));
        repeat (3) step();
        chk("t5_nogrant", 64'(grant), 64'(0));
        bus.req_write = '0;
        en = 1'b1;

        // 6: reset at beat 2 of an 8-beat burst aborts and clears the pointer.
        set_req(0, 10'h066, 32'h6666_0000, 8);
        bus.req_write = 2'b01;
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_grant", 64'(grant), 64'(0));
        chk("t6_write", 64'(bus.slave_write), 64'(0));
        chk("t6_waitreq", 64'(bus.req_waitrequest), 64'({NREQ{1'b1}}));
        set_req(1, 10'h166, 32'h1666_0000, 1);
        set_req(0, 10'h066, 32'h6666_0000, 1);
        bus.req_write = 2'b11;
        step();
        chk("t6_ptr0", 64'(grant), 64'(2'b01));
        drain();

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            en                    = ($urandom_range(0, 7) != 0);
            bus.req_write         = NREQ'($urandom);
            bus.slave_waitrequest = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NREQ; k++) begin
                set_req(k, int'($urandom), int'($urandom), int'($urandom_range(0, 15)));
            end
            step();
        end
        en = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
